note_sequencer: RTL and testbench



---
 rtl/audio_pkg.sv | 35 +++
 rtl/note_ram.sv | 27 ++
 rtl/note_sequencer.sv | 173 +++++++++++++++++
 tb/tb_note_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the voice note sequencer: note table entry layout
// and sequencer FSM states.
package audio_pkg;

   localparam int ENTRY_W   = 48;

   localparam int PITCH_LSB = 32;
   localparam int PITCH_W   = 16;
   localparam int A_LSB     = 24;
   localparam int A_W       = 8;
   localparam int R_LSB     = 16;
   localparam int R_W       = 8;
   localparam int GLEN_LSB  = 8;
   localparam int GLEN_W    = 8;
   localparam int DUR_LSB   = 0;
   localparam int DUR_W     = 8;

   // Field order matches the offsets above, MSB first.
   typedef struct packed {
      logic [PITCH_W-1:0] pitch;
      logic [A_W-1:0]     a;
      logic [R_W-1:0]     r;
      logic [GLEN_W-1:0]  gate_len;
      logic [DUR_W-1:0]   duration;
   } note_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_ARM      = 3'd2,
      ST_GATE_ON  = 3'd3,
      ST_GATE_OFF = 3'd4
   } state_e;

endpackage

// File: rtl/note_ram.sv
// Note table: DEPTH x ENTRY_W single-write, synchronous-read memory.
// A read and a write to the same address in one cycle return the old data.
module note_ram
   import audio_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic [ENTRY_W-1:0] wr_data_i,
   input  logic [AW-1:0]      rd_addr_i,
   output logic [ENTRY_W-1:0] rd_data_o
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/note_sequencer.sv
// Steps through the note table, driving one voice's gate/attack/release and
// oscillator pitch; all note timing is counted in sample_clock strobes.
module note_sequencer
   import audio_pkg::*;
#(
   parameter  int DEPTH   = 16,
   parameter  int TICKDIV = 256,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_clock,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic [AW-1:0]      last,
   input  logic               loop,
   input  logic               start,
   input  logic               stop,
   output logic               gate,
   output logic [7:0]         a,
   output logic [7:0]         r,
   output logic [15:0]        pitch,
   output logic               busy,
   output logic [AW-1:0]      step_idx,
   output logic               done
);

   localparam int            PW        = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKDIV - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] step_q, step_d;
   logic          gate_q, gate_d;
   logic [7:0]    a_q, a_d;
   logic [7:0]    r_q, r_d;
   logic [15:0]   pitch_q, pitch_d;
   logic [7:0]    glen_q, glen_d;
   logic [7:0]    dur_q, dur_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    tick_q, tick_d;
   logic          done_q, done_d;

   note_t         rd_note;
   logic          wrap;
   logic [8:0]    tick_inc;
   logic [8:0]    dur_eff;
   logic          note_end;

   // Read address follows the next step so the entry is ready during FETCH.
   note_ram #(.DEPTH(DEPTH)) u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_addr_i (step_d),
      .rd_data_o (rd_note)
   );

   assign wrap     = sample_clock && (presc_q == PRESC_MAX);
   assign tick_inc = {1'b0, tick_q} + 9'd1;
   assign dur_eff  = (dur_q == 8'd0) ? 9'd256 : {1'b0, dur_q};
   assign note_end = wrap && (tick_inc == dur_eff);

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      gate_d  = gate_q;
      a_d     = a_q;
      r_d     = r_q;
      pitch_d = pitch_q;
      glen_d  = glen_q;
      dur_d   = dur_q;
      presc_d = presc_q;
      tick_d  = tick_q;
      done_d  = 1'b0;

      if (stop) begin
         // a/r/pitch hold so the envelope finishes its release on the current note
         state_d = ST_IDLE;
         gate_d  = 1'b0;
      end else if (start) begin
         state_d = ST_FETCH;
         step_d  = '0;
         gate_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_FETCH: begin
               pitch_d = rd_note.pitch;
               a_d     = rd_note.a;
               r_d     = rd_note.r;
               glen_d  = rd_note.gate_len;
               dur_d   = rd_note.duration;
               gate_d  = 1'b0;
               state_d = ST_ARM;
            end
            ST_ARM: begin
               // Waiting for a strobe guarantees a full sample of gate low before retrigger.
               if (sample_clock) begin
                  presc_d = '0;
                  tick_d  = '0;
                  if (glen_q != 8'd0) begin
                     gate_d  = 1'b1;
                     state_d = ST_GATE_ON;
                  end else begin
                     state_d = ST_GATE_OFF;
                  end
               end
            end
            ST_GATE_ON, ST_GATE_OFF: begin
               if (sample_clock) presc_d = wrap ? '0 : presc_q + PW'(1);
               if (wrap) tick_d = tick_inc[7:0];
               if (state_q == ST_GATE_ON && wrap && tick_inc == {1'b0, glen_q}) begin
                  gate_d  = 1'b0;
                  state_d = ST_GATE_OFF;
               end
               if (note_end) begin
                  gate_d = 1'b0;
                  if (step_q != last) begin
                     step_d  = step_q + AW'(1);
                     state_d = ST_FETCH;
                  end else if (loop) begin
                     step_d  = '0;
                     state_d = ST_FETCH;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         gate_q  <= 1'b0;
         a_q     <= '0;
         r_q     <= '0;
         pitch_q <= '0;
         glen_q  <= '0;
         dur_q   <= '0;
         presc_q <= '0;
         tick_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         gate_q  <= gate_d;
         a_q     <= a_d;
         r_q     <= r_d;
         pitch_q <= pitch_d;
         glen_q  <= glen_d;
         dur_q   <= dur_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   assign gate     = gate_q;
   assign a        = a_q;
   assign r        = r_q;
   assign pitch    = pitch_q;
   assign busy     = (state_q != ST_IDLE);
   assign step_idx = step_q;
   assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: gate edges and done pulses are matched
// against hand-computed events, timed in strobes relative to the start pulse.
module tb_note_sequencer;

   localparam int EV_RISE = 1;
   localparam int EV_FALL = 2;
   localparam int EV_DONE = 3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [7:0]  rel;
      logic [3:0]  step;
      logic        busy;
      logic [15:0] pitch;
      logic [7:0]  a;
      logic [7:0]  r;
   } ev_t;

   logic        clk, rst, sample_clock, wr_en, loop, start, stop;
   logic [3:0]  wr_addr, last;
   logic [47:0] wr_data;
   logic        gate, busy, done;
   logic [7:0]  a, r;
   logic [15:0] pitch;
   logic [3:0]  step_idx;

   int   ncmp = 0;
   int   nmis = 0;
   int   scnt = 0;
   int   t0   = 0;
   logic mon_pg = 1'b0;
   ev_t  expq[$];

   note_sequencer #(.DEPTH(16), .TICKDIV(4)) dut (
      .clk(clk), .rst(rst), .sample_clock(sample_clock),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .last(last), .loop(loop), .start(start), .stop(stop),
      .gate(gate), .a(a), .r(r), .pitch(pitch), .busy(busy),
      .step_idx(step_idx), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      sample_clock = 1'b0;
      forever begin
         repeat (255) @(negedge clk);
         sample_clock = 1'b1;
         @(negedge clk);
         sample_clock = 1'b0;
      end
   end

   always @(posedge clk) if (sample_clock) scnt <= scnt + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic ex(input int k, input int rel, input int st, input logic b,
                     input logic [15:0] p, input logic [7:0] aa, input logic [7:0] rr);
      ev_t e;
      e.kind = 2'(k); e.rel = 8'(rel); e.step = 4'(st); e.busy = b;
      e.pitch = p; e.a = aa; e.r = rr;
      expq.push_back(e);
   endtask

   task automatic log_ev(input int k);
      ev_t got, want;
      got.kind = 2'(k); got.rel = 8'(scnt - t0); got.step = step_idx; got.busy = busy;
      got.pitch = (k == EV_RISE) ? pitch : 16'h0;
      got.a     = (k == EV_RISE) ? a : 8'h0;
      got.r     = (k == EV_RISE) ? r : 8'h0;
      if (expq.size() == 0) begin
         ncmp++; nmis++;
         $display("FAIL unexpected_event: got %h expected none", got);
      end else begin
         want = expq.pop_front();
         chk("event", 64'(got), 64'(want));
      end
   endtask

   // Monitor: every gate edge and done pulse must match the next queued event.
   initial begin
      forever begin
         @(negedge clk);
         if (gate !== mon_pg) log_ev(gate ? EV_RISE : EV_FALL);
         if (done === 1'b1) log_ev(EV_DONE);
         mon_pg = gate;
      end
   end

   task automatic wr(input int ad, input logic [15:0] p, input logic [7:0] aa,
                     input logic [7:0] rr, input logic [7:0] gl, input logic [7:0] du);
      wr_en = 1'b1; wr_addr = 4'(ad); wr_data = {p, aa, rr, gl, du};
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic sync_go();
      @(posedge clk iff sample_clock);
      repeat (10) @(negedge clk);
      start = 1'b1; t0 = scnt;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_rel(input int k);
      while (scnt < t0 + k) @(negedge clk);
      repeat (5) @(negedge clk);
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      last = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {gate, a, r, pitch, busy, step_idx, done}, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_outputs", {gate, a, r, pitch, busy, step_idx, done}, 0);

      // Single note: gate 2 ticks (8 strobes), note 5 ticks (20 strobes).
      wr(0, 16'h1234, 8'd255, 8'd30, 8'd2, 8'd5);
      last = 4'd0; loop = 1'b0;
      ex(EV_RISE, 1, 0, 1, 16'h1234, 8'd255, 8'd30);
      ex(EV_FALL, 9, 0, 1, 0, 0, 0);
      ex(EV_DONE, 21, 0, 0, 0, 0, 0);
      sync_go();
      chk("fetch_busy", busy, 1);
      chk("fetch_pitch_not_yet", pitch, 0);
      @(negedge clk);
      chk("latched_fields", {gate, pitch, a, r}, {1'b0, 16'h1234, 8'd255, 8'd30});
      wait_rel(23);
      chk("single_idle", busy, 0);
      chk("single_drain", expq.size(), 0);

      // Two-note loop; entry 1 has gate_len == duration.
      wr(0, 16'h0100, 8'd10, 8'd20, 8'd1, 8'd2);
      wr(1, 16'h0200, 8'd11, 8'd21, 8'd2, 8'd2);
      last = 4'd1; loop = 1'b1;
      ex(EV_RISE, 1, 0, 1, 16'h0100, 8'd10, 8'd20);
      ex(EV_FALL, 5, 0, 1, 0, 0, 0);
      ex(EV_RISE, 10, 1, 1, 16'h0200, 8'd11, 8'd21);
      ex(EV_FALL, 18, 0, 1, 0, 0, 0);
      ex(EV_RISE, 19, 0, 1, 16'h0100, 8'd10, 8'd20);
      ex(EV_FALL, 23, 0, 1, 0, 0, 0);
      ex(EV_RISE, 28, 1, 1, 16'h0200, 8'd11, 8'd21);
      ex(EV_FALL, 36, 0, 1, 0, 0, 0);
      sync_go();
      wait_rel(36);
      chk("loop_still_busy", busy, 1);
      pulse_stop();
      chk("loop_stop_idle", busy, 0);
      chk("loop_drain", expq.size(), 0);

      // Stop during GATE_ON.
      wr(0, 16'hBEEF, 8'd77, 8'd88, 8'd4, 8'd6);
      last = 4'd0; loop = 1'b0;
      ex(EV_RISE, 1, 0, 1, 16'hBEEF, 8'd77, 8'd88);
      ex(EV_FALL, 3, 0, 0, 0, 0, 0);
      sync_go();
      wait_rel(3);
      chk("pre_stop_gate", gate, 1);
      pulse_stop();
      chk("stop_gate_busy", {gate, busy}, 2'b00);
      chk("stop_hold", {pitch, a, r}, {16'hBEEF, 8'd77, 8'd88});
      repeat (600) @(negedge clk);
      chk("stop_drain", expq.size(), 0);

      // gate_len == duration == 3, then a one-tick last note.
      wr(0, 16'h0300, 8'd1, 8'd2, 8'd3, 8'd3);
      wr(1, 16'h0400, 8'd3, 8'd4, 8'd1, 8'd1);
      last = 4'd1; loop = 1'b0;
      ex(EV_RISE, 1, 0, 1, 16'h0300, 8'd1, 8'd2);
      ex(EV_FALL, 13, 1, 1, 0, 0, 0);
      ex(EV_RISE, 14, 1, 1, 16'h0400, 8'd3, 8'd4);
      ex(EV_FALL, 18, 1, 0, 0, 0, 0);
      ex(EV_DONE, 18, 1, 0, 0, 0, 0);
      sync_go();
      wait_rel(20);
      chk("eq_drain", expq.size(), 0);

      // gate_len = 0: no gate, note still lasts 2 ticks.
      wr(0, 16'h0500, 8'd5, 8'd6, 8'd0, 8'd2);
      last = 4'd0;
      ex(EV_DONE, 9, 0, 0, 0, 0, 0);
      sync_go();
      wait_rel(11);
      chk("glen0_drain", expq.size(), 0);

      // start and stop together: stop wins.
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("race_idle", busy, 0);
      repeat (300) @(negedge clk);
      chk("race_quiet", {gate, busy, done}, 3'b000);

      // Restart during note 1.
      wr(0, 16'h0600, 8'd6, 8'd7, 8'd1, 8'd2);
      wr(1, 16'h0700, 8'd8, 8'd9, 8'd2, 8'd3);
      last = 4'd1; loop = 1'b1;
      ex(EV_RISE, 1, 0, 1, 16'h0600, 8'd6, 8'd7);
      ex(EV_FALL, 5, 0, 1, 0, 0, 0);
      ex(EV_RISE, 10, 1, 1, 16'h0700, 8'd8, 8'd9);
      ex(EV_FALL, 11, 0, 1, 0, 0, 0);
      ex(EV_RISE, 12, 0, 1, 16'h0600, 8'd6, 8'd7);
      ex(EV_FALL, 16, 0, 1, 0, 0, 0);
      sync_go();
      wait_rel(11);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_rel(17);
      pulse_stop();
      chk("restart_stop_idle", busy, 0);
      chk("restart_drain", expq.size(), 0);

      // Rewrite entry 0 while it plays; the next loop pass uses the new data.
      wr(0, 16'h0800, 8'd1, 8'd1, 8'd1, 8'd2);
      wr(1, 16'h0900, 8'd2, 8'd2, 8'd1, 8'd2);
      ex(EV_RISE, 1, 0, 1, 16'h0800, 8'd1, 8'd1);
      ex(EV_FALL, 5, 0, 1, 0, 0, 0);
      ex(EV_RISE, 10, 1, 1, 16'h0900, 8'd2, 8'd2);
      ex(EV_FALL, 14, 1, 1, 0, 0, 0);
      ex(EV_RISE, 19, 0, 1, 16'h5555, 8'd99, 8'd1);
      ex(EV_FALL, 20, 0, 0, 0, 0, 0);
      sync_go();
      wait_rel(2);
      wr(0, 16'h5555, 8'd99, 8'd1, 8'd1, 8'd2);
      wait_rel(20);
      pulse_stop();
      chk("rewrite_drain", expq.size(), 0);

      // Asynchronous reset mid-note.
      wr(0, 16'hABCD, 8'd12, 8'd34, 8'd4, 8'd6);
      last = 4'd0; loop = 1'b0;
      ex(EV_RISE, 1, 0, 1, 16'hABCD, 8'd12, 8'd34);
      ex(EV_FALL, 2, 0, 0, 0, 0, 0);
      sync_go();
      wait_rel(2);
      chk("pre_reset_gate", gate, 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 chk("async_reset_outputs", {gate, a, r, pitch, busy, step_idx, done}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (600) @(negedge clk);
      chk("reset_hold_outputs", {gate, a, r, pitch, busy, step_idx, done}, 0);
      chk("final_drain", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

endmodule
